cif_cmd_exec: RTL and testbench

CIF_CMD_EXEC -- requirements
Module: cif_cmd_exec

---
 rtl/cif_pkg.sv | 61 ++++++
 rtl/cif_cmd_exec_if.sv | 35 +++
 rtl/cif_tag_fifo.sv | 56 +++++
 rtl/cif_cmd_exec.sv | 144 ++++++++++++++
 tb/tb_cif_cmd_exec.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cif_pkg.sv
// Shared encodings and field layouts for the CIF command executor.
// Commands, events and tag entries are described as packed structs so bit positions live in one place.
package cif_pkg;

   localparam logic [7:0] OP_NOP      = 8'h00;
   localparam logic [7:0] OP_TRANSFER = 8'h01;

   localparam logic [7:0] ST_ILLEGAL_OP = 8'h01;
   localparam logic [7:0] ST_ZERO_LEN   = 8'h02;

   localparam logic [7:0] EVT_DONE = 8'h10;
   localparam logic [7:0] EVT_ERR  = 8'hE0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_ERR_EVT
   } cmd_state_e;

   // 64-bit command word, MSB first.
   typedef struct packed {
      logic [7:0]  op;
      logic [3:0]  rsvd;
      logic [3:0]  chan;
      logic [15:0] tid;
      logic [31:0] len;
   } cmd_t;

   // 128-bit event word, MSB first.
   typedef struct packed {
      logic [7:0]  code;
      logic [7:0]  status;
      logic [15:0] tid;
      logic [31:0] len;
      logic [31:0] rsvd;
      logic [31:0] seq;
   } event_t;

   typedef struct packed {
      logic [15:0] tid;
      logic [31:0] len;
   } tag_t;

   function automatic event_t make_event(
      input logic [7:0]  code,
      input logic [7:0]  status,
      input logic [15:0] tid,
      input logic [31:0] len,
      input logic [31:0] seq
   );
      event_t e;
      e        = '0;
      e.code   = code;
      e.status = status;
      e.tid    = tid;
      e.len    = len;
      e.seq    = seq;
      return e;
   endfunction

endpackage

// File: rtl/cif_cmd_exec_if.sv
// Stream bundle between the command executor, the clock-crossing FIFOs and the DMA engine.
// The executor uses the slave view; the surrounding fabric (or a bench) uses the master view.
interface cif_cmd_exec_if;

   logic        cmd_valid;
   logic [63:0] cmd_data;
   logic        cmd_ready;

   logic         eve_valid;
   logic [127:0] eve_data;
   logic         eve_ready;

   logic        xfer_req_valid;
   logic        xfer_req_ready;
   logic [3:0]  xfer_req_chan;
   logic [31:0] xfer_req_len;
   logic [15:0] xfer_req_tid;

   logic        xfer_done_valid;
   logic        xfer_done_ready;
   logic [7:0]  xfer_done_status;

   modport slave (
      input  cmd_valid, cmd_data, eve_ready, xfer_req_ready, xfer_done_valid, xfer_done_status,
      output cmd_ready, eve_valid, eve_data, xfer_req_valid, xfer_req_chan, xfer_req_len,
             xfer_req_tid, xfer_done_ready
   );

   modport master (
      output cmd_valid, cmd_data, eve_ready, xfer_req_ready, xfer_done_valid, xfer_done_status,
      input  cmd_ready, eve_valid, eve_data, xfer_req_valid, xfer_req_chan, xfer_req_len,
             xfer_req_tid, xfer_done_ready
   );

endinterface

// File: rtl/cif_tag_fifo.sv
// In-order tag store for issued transfers; occupancy doubles as the outstanding-transfer count.
// DEPTH must be a power of two so the pointers wrap naturally.
module cif_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 48
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int             AW      = $clog2(DEPTH);
   localparam logic [AW-1:0]  PTR_ONE = AW'(1);
   localparam logic [AW:0]    CNT_ONE = (AW + 1)'(1);
   localparam logic [AW:0]    CNT_MAX = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count == CNT_MAX);
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is left out of reset; only the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/cif_cmd_exec.sv
// Command executor: decodes commands, issues DMA transfer requests, and turns in-order
// completions and command errors into events through a single-entry output register.
module cif_cmd_exec
   import cif_pkg::*;
#(
   parameter int MAX_OUTST = 4
) (
   input  logic          user_clk,
   input  logic          reset,
   cif_cmd_exec_if.slave bus,
   output logic          err_unexp_done
);

   cmd_state_e  state;
   cmd_t        cmd;
   logic        cmd_unused;

   logic [3:0]  req_chan;
   logic [15:0] req_tid;
   logic [31:0] req_len;
   logic        req_valid;
   logic [7:0]  err_status;

   logic        eve_valid_q;
   event_t      eve_q;
   event_t      eve_next;
   logic [31:0] seq;

   tag_t        tag_head;
   logic        tag_full;
   logic        tag_empty;

   logic        cmd_fire;
   logic        issue_fire;
   logic        done_fire;
   logic        done_evt;
   logic        unexp_done;
   logic        slot_free;
   logic        err_load;
   logic        eve_load;

   assign cmd        = bus.cmd_data;
   assign cmd_unused = ^cmd.rsvd;

   assign slot_free  = !eve_valid_q || bus.eve_ready;
   assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
   assign issue_fire = (state == S_ISSUE) && bus.xfer_req_ready;
   assign done_fire  = bus.xfer_done_valid && bus.xfer_done_ready;
   assign done_evt   = done_fire && !tag_empty;
   assign unexp_done = done_fire && tag_empty;
   // A completion always wins the event slot over a pending error event.
   assign err_load   = (state == S_ERR_EVT) && slot_free && !done_fire;
   assign eve_load   = done_evt || err_load;

   assign eve_next = done_evt
      ? make_event(EVT_DONE, bus.xfer_done_status, tag_head.tid, tag_head.len, seq)
      : make_event(EVT_ERR, err_status, req_tid, req_len, seq);

   // Ready terms are gated by reset so they read low while reset is held.
   assign bus.cmd_ready       = !reset && (state == S_IDLE) && !tag_full;
   assign bus.xfer_done_ready = !reset && slot_free;

   assign bus.xfer_req_valid = req_valid;
   assign bus.xfer_req_chan  = req_chan;
   assign bus.xfer_req_tid   = req_tid;
   assign bus.xfer_req_len   = req_len;
   assign bus.eve_valid      = eve_valid_q;
   assign bus.eve_data       = eve_q;

   cif_tag_fifo #(
      .DEPTH (MAX_OUTST),
      .WIDTH ($bits(tag_t))
   ) u_tag_fifo (
      .clk       (user_clk),
      .reset     (reset),
      .push      (issue_fire),
      .push_data ({req_tid, req_len}),
      .pop       (done_evt),
      .pop_data  (tag_head),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   // NOTE: every register here uses <= so all updates see pre-edge values, as the hardware does.
   always_ff @(posedge user_clk) begin
      if (reset) begin
         state      <= S_IDLE;
         req_valid  <= 1'b0;
         req_chan   <= '0;
         req_tid    <= '0;
         req_len    <= '0;
         err_status <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cmd_fire) begin
                  req_chan <= cmd.chan;
                  req_tid  <= cmd.tid;
                  req_len  <= cmd.len;
                  if (cmd.op == OP_TRANSFER && cmd.len != '0) begin
                     req_valid <= 1'b1;
                     state     <= S_ISSUE;
                  end else if (cmd.op == OP_TRANSFER) begin
                     err_status <= ST_ZERO_LEN;
                     state      <= S_ERR_EVT;
                  end else if (cmd.op != OP_NOP) begin
                     err_status <= ST_ILLEGAL_OP;
                     state      <= S_ERR_EVT;
                  end
               end
            end
            S_ISSUE: begin
               if (bus.xfer_req_ready) begin
                  req_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            S_ERR_EVT: begin
               if (err_load) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge user_clk) begin
      if (reset) begin
         eve_valid_q    <= 1'b0;
         eve_q          <= '0;
         seq            <= '0;
         err_unexp_done <= 1'b0;
      end else begin
         if (eve_load) begin
            eve_valid_q <= 1'b1;
            eve_q       <= eve_next;
            seq         <= seq + 32'd1;
         end else if (bus.eve_ready) begin
            eve_valid_q <= 1'b0;
         end
         if (unexp_done) err_unexp_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cif_cmd_exec.sv
// Directed bench for cif_cmd_exec: issue, back-pressure, error events, stalls, unexpected done, reset.
`timescale 1ns/1ps
module tb_cif_cmd_exec;

   logic user_clk;
   logic reset;
   logic err_unexp_done;
   int   errors;
   int   checks;

   cif_cmd_exec_if bus ();

   cif_cmd_exec #(.MAX_OUTST(4)) dut (
      .user_clk       (user_clk),
      .reset          (reset),
      .bus            (bus),
      .err_unexp_done (err_unexp_done)
   );

   initial user_clk = 1'b0;
   always #5 user_clk = ~user_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge user_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mk_cmd(input logic [7:0] op, input logic [3:0] chan,
                                          input logic [15:0] tid, input logic [31:0] len);
      return {op, 4'hF, chan, tid, len};
   endfunction

   function automatic logic [127:0] exp_evt(input logic [7:0] code, input logic [7:0] status,
                                            input logic [15:0] tid, input logic [31:0] len,
                                            input logic [31:0] seq);
      return {code, status, tid, len, 32'h0, seq};
   endfunction

   initial begin
      logic [127:0] held;
      logic         stable_ok;
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      bus.cmd_valid        = 1'b0;
      bus.cmd_data         = '0;
      bus.eve_ready        = 1'b0;
      bus.xfer_req_ready   = 1'b0;
      bus.xfer_done_valid  = 1'b0;
      bus.xfer_done_status = '0;
      step(); step(); step();

      // Reset state
      check("rst_cmd_ready", bus.cmd_ready, 1'b0);
      check("rst_eve_valid", bus.eve_valid, 1'b0);
      check("rst_req_valid", bus.xfer_req_valid, 1'b0);
      check("rst_done_ready", bus.xfer_done_ready, 1'b0);
      check("rst_err_unexp", err_unexp_done, 1'b0);
      check("rst_eve_data", bus.eve_data, 128'h0);
      reset = 1'b0;
      #1;
      check("idle_cmd_ready", bus.cmd_ready, 1'b1);

      // Single transfer, request one cycle after accept, completion event seq 0
      bus.cmd_data  = mk_cmd(8'h01, 4'h3, 16'h1234, 32'h100);
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      check("t1_req_valid", bus.xfer_req_valid, 1'b1);
      check("t1_req_fields", {bus.xfer_req_chan, bus.xfer_req_tid, bus.xfer_req_len},
            {4'h3, 16'h1234, 32'h100});
      check("t1_cmd_ready_issue", bus.cmd_ready, 1'b0);
      step();
      check("t1_req_held", {bus.xfer_req_valid, bus.xfer_req_tid}, {1'b1, 16'h1234});
      bus.xfer_req_ready = 1'b1;
      step();
      bus.xfer_req_ready = 1'b0;
      check("t1_req_dropped", bus.xfer_req_valid, 1'b0);
      bus.xfer_done_valid  = 1'b1;
      bus.xfer_done_status = 8'h00;
      #1;
      check("t1_done_ready", bus.xfer_done_ready, 1'b1);
      step();
      bus.xfer_done_valid = 1'b0;
      check("t1_eve_valid", bus.eve_valid, 1'b1);
      check("t1_eve_data", bus.eve_data, exp_evt(8'h10, 8'h00, 16'h1234, 32'h100, 32'd0));
      bus.eve_ready = 1'b1;
      step();
      check("t1_eve_drained", bus.eve_valid, 1'b0);

      // Outstanding limit: four issue, fifth waits for a completion
      bus.xfer_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("lim_cmd_ready", bus.cmd_ready, 1'b1);
         bus.cmd_data  = mk_cmd(8'h01, 4'h1, 16'h0A00 + 16'(i), 32'h10 * 32'(i + 1));
         bus.cmd_valid = 1'b1;
         step();
         bus.cmd_valid = 1'b0;
         check("lim_req_tid", bus.xfer_req_tid, 16'h0A00 + 16'(i));
         step();
      end
      check("lim_full_cmd_ready", bus.cmd_ready, 1'b0);
      bus.cmd_data  = mk_cmd(8'h01, 4'h1, 16'h0A04, 32'h50);
      bus.cmd_valid = 1'b1;
      step(); step();
      check("lim_blocked", {bus.cmd_ready, bus.xfer_req_valid}, 2'b00);
      bus.xfer_done_valid  = 1'b1;
      bus.xfer_done_status = 8'h00;
      step();
      bus.xfer_done_valid = 1'b0;
      check("lim_first_done", bus.eve_data, exp_evt(8'h10, 8'h00, 16'h0A00, 32'h10, 32'd1));
      check("lim_room_again", bus.cmd_ready, 1'b1);
      step();
      bus.cmd_valid = 1'b0;
      check("lim_fifth_req", {bus.xfer_req_valid, bus.xfer_req_tid}, {1'b1, 16'h0A04});
      step();
      check("lim_full_again", bus.cmd_ready, 1'b0);
      bus.xfer_req_ready  = 1'b0;
      bus.xfer_done_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         check("lim_inorder", bus.eve_data,
               exp_evt(8'h10, 8'h00, 16'h0A00 + 16'(i), 32'h10 * 32'(i + 1), 32'(1 + i)));
      end
      bus.xfer_done_valid = 1'b0;
      step();
      bus.eve_ready = 1'b0;
      check("lim_all_done", {bus.eve_valid, bus.cmd_ready}, 2'b01);

      // Illegal opcode then zero-length transfer produce error events, no request
      bus.cmd_data  = mk_cmd(8'h7F, 4'h0, 16'h00EE, 32'h5);
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      check("err1_no_req", {bus.xfer_req_valid, bus.cmd_ready}, 2'b00);
      step();
      check("err1_code_status", {bus.eve_valid, bus.eve_data[127:112]}, {1'b1, 16'hE001});
      check("err1_seq", bus.eve_data[31:0], 32'd6);
      bus.cmd_data  = mk_cmd(8'h01, 4'h2, 16'h00EF, 32'h0);
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      check("err2_no_req", bus.xfer_req_valid, 1'b0);
      check("err2_first_held", bus.eve_data[127:112], 16'hE001);
      bus.eve_ready = 1'b1;
      step();
      bus.eve_ready = 1'b0;
      check("err2_code_status", {bus.eve_valid, bus.eve_data[127:112]}, {1'b1, 16'hE002});
      check("err2_seq", bus.eve_data[31:0], 32'd7);
      bus.cmd_data  = mk_cmd(8'h00, 4'h0, 16'h0, 32'h0);
      bus.cmd_valid = 1'b1;
      bus.eve_ready = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      bus.eve_ready = 1'b0;
      check("nop_quiet", {bus.eve_valid, bus.xfer_req_valid, bus.cmd_ready}, 3'b001);

      // Event back-pressure with a pending completion
      bus.xfer_req_ready = 1'b1;
      bus.cmd_data  = mk_cmd(8'h01, 4'h7, 16'h5555, 32'h40);
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      step();
      bus.cmd_data  = mk_cmd(8'h01, 4'h7, 16'h6666, 32'h80);
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      step();
      bus.xfer_req_ready   = 1'b0;
      bus.xfer_done_valid  = 1'b1;
      bus.xfer_done_status = 8'h33;
      step();
      bus.xfer_done_status = 8'h44;
      held = exp_evt(8'h10, 8'h33, 16'h5555, 32'h40, 32'd8);
      check("stall_first_evt", bus.eve_data, held);
      check("stall_done_ready", bus.xfer_done_ready, 1'b0);
      stable_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.xfer_done_ready !== 1'b0 || bus.eve_valid !== 1'b1 || bus.eve_data !== held)
            stable_ok = 1'b0;
      end
      check("stall_stable", stable_ok, 1'b1);
      bus.eve_ready = 1'b1;
      #1;
      check("stall_release_ready", bus.xfer_done_ready, 1'b1);
      step();
      bus.xfer_done_valid = 1'b0;
      check("stall_second_evt", bus.eve_data, exp_evt(8'h10, 8'h44, 16'h6666, 32'h80, 32'd9));
      step();
      bus.eve_ready = 1'b0;
      check("stall_drained", bus.eve_valid, 1'b0);

      // Completion with nothing outstanding
      bus.xfer_done_valid  = 1'b1;
      bus.xfer_done_status = 8'h99;
      step();
      bus.xfer_done_valid = 1'b0;
      check("unexp_flag", {err_unexp_done, bus.eve_valid}, 2'b10);
      step();
      check("unexp_sticky", err_unexp_done, 1'b1);

      // Reset while a request is being offered
      bus.cmd_data  = mk_cmd(8'h01, 4'h2, 16'h7777, 32'h8);
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      check("mid_issue_valid", bus.xfer_req_valid, 1'b1);
      reset = 1'b1;
      step();
      check("mid_rst_ctrl", {bus.cmd_ready, bus.eve_valid, bus.xfer_req_valid,
                             bus.xfer_done_ready, err_unexp_done}, 5'b00000);
      check("mid_rst_data", {bus.eve_data, bus.xfer_req_chan, bus.xfer_req_tid, bus.xfer_req_len},
            '0);
      reset = 1'b0;
      #1;
      check("post_rst_ready", {bus.cmd_ready, err_unexp_done}, 2'b10);

      // Sequence numbering restarts at zero after reset
      bus.xfer_req_ready = 1'b1;
      bus.cmd_data  = mk_cmd(8'h01, 4'h5, 16'h0042, 32'h1);
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      step();
      bus.xfer_req_ready   = 1'b0;
      bus.xfer_done_valid  = 1'b1;
      bus.xfer_done_status = 8'h00;
      step();
      bus.xfer_done_valid = 1'b0;
      check("post_rst_seq0", bus.eve_data, exp_evt(8'h10, 8'h00, 16'h0042, 32'h1, 32'd0));
      bus.eve_ready = 1'b1;
      step();
      bus.eve_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
